// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - scanner FSM states, reset column and key code table (code table used with TECLADO_CODE_EN)
package teclado_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    REPORT,
    STROBE,
    RELEASE
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1000;

  // Indexed by {row index, column index}; index 0 is the top row / left column.
  localparam logic [15:0][3:0] CODE_TABLE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] lin, input logic [3:0] col);
    return CODE_TABLE[{onehot_idx(lin), onehot_idx(col)}];
  endfunction

endpackage

// File: rtl/teclado_if.sv
// rtl/teclado_if.sv - accepted-key interface lin/col/bot_press (code/code_valid with TECLADO_CODE_EN)
interface teclado_if;

  logic [3:0] lin;
  logic [3:0] col;
  logic       bot_press;

`ifdef TECLADO_CODE_EN
  logic [3:0] code;
  logic       code_valid;

  modport master (output lin, col, bot_press, code, code_valid);
  modport slave  (input  lin, col, bot_press, code, code_valid);
`else
  modport master (output lin, col, bot_press);
  modport slave  (input  lin, col, bot_press);
`endif

endinterface

// File: rtl/teclado_sinc.sv
// rtl/teclado_sinc.sv - 4-bit two-flop synchronizer with synchronous clear
module teclado_sinc (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_varredura.sv
// rtl/teclado_varredura.sv - 4x4 keypad scanner with press/release debounce; TECLADO_CODE_EN adds code/code_valid
module teclado_varredura
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  teclado_if.master  kb
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  state_t           state, state_next;
  logic [3:0]       row_s;
  logic [3:0]       row_cap, row_cap_next;
  logic [3:0]       col_next;
  logic [3:0]       lin_r, lin_next;
  logic [3:0]       col_r, col_key_next;
  logic             press_r, press_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [DEB_W-1:0] deb_cnt, deb_next;

  teclado_sinc u_sinc (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      col_out <= COL_RESET;
      row_cap <= '0;
      div_cnt <= '0;
      deb_cnt <= '0;
      lin_r   <= '0;
      col_r   <= '0;
      press_r <= 1'b0;
    end else begin
      state   <= state_next;
      col_out <= col_next;
      row_cap <= row_cap_next;
      div_cnt <= div_next;
      deb_cnt <= deb_next;
      lin_r   <= lin_next;
      col_r   <= col_key_next;
      press_r <= press_next;
    end
  end

  // bot_press is registered off STROBE so lin/col lead it by exactly one cycle.
  always_comb begin
    state_next   = state;
    col_next     = col_out;
    row_cap_next = row_cap;
    div_next     = div_cnt;
    deb_next     = deb_cnt;
    lin_next     = lin_r;
    col_key_next = col_r;
    press_next   = 1'b0;

    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if ($onehot(row_s)) begin
            row_cap_next = row_s;
            deb_next     = '0;
            state_next   = DEBOUNCE;
          end else begin
            col_next = {col_out[0], col_out[3:1]};
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s != row_cap) begin
          div_next   = '0;
          deb_next   = '0;
          state_next = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          deb_next   = '0;
          state_next = REPORT;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      REPORT: begin
        lin_next     = row_cap;
        col_key_next = col_out;
        state_next   = STROBE;
      end

      STROBE: begin
        press_next = 1'b1;
        deb_next   = '0;
        state_next = RELEASE;
      end

      RELEASE: begin
        if (row_s != 4'b0000) begin
          deb_next = '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_next   = '0;
          div_next   = '0;
          state_next = SCAN;
        end else begin
          deb_next = deb_cnt + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  assign kb.lin       = lin_r;
  assign kb.col       = col_r;
  assign kb.bot_press = press_r;

`ifdef TECLADO_CODE_EN
  logic [3:0] code_r;
  logic       code_valid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      code_r       <= '0;
      code_valid_r <= 1'b0;
    end else begin
      code_valid_r <= press_next;
      if (state == REPORT) begin
        code_r <= key_code(row_cap, col_out);
      end
    end
  end

  assign kb.code       = code_r;
  assign kb.code_valid = code_valid_r;
`endif

endmodule

// File: tb/tb_teclado_varredura.sv
// tb/tb_teclado_varredura.sv - scoreboard bench for the keypad scanner (checks code when TECLADO_CODE_EN is set)
module tb_teclado_varredura;
  import teclado_pkg::*;

  typedef struct packed {
    logic [3:0] lin;
    logic [3:0] col;
    logic [3:0] code;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_row;
  logic [3:0] key_col;

  int   checks;
  int   errors;
  int   strobe_cnt;
  int   cyc;
  int   strobe_times[$];
  exp_t exp_q[$];

  logic [3:0] prev_lin;
  logic [3:0] prev_col;
  logic       prev_press;

  teclado_if kb ();

  teclado_varredura #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .kb      (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its column drive to its row.
  always @* row_in = ((col_out & key_col) != 4'b0000) ? key_row : 4'b0000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per strobe and compares the key held on the bus.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (kb.bot_press === 1'b1) begin
      strobe_cnt++;
      strobe_times.push_back(cyc);
      check("strobe_single_cycle", {7'b0, prev_press}, 8'h00);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 8'h01, 8'h00);
      end else begin
        e = exp_q.pop_front();
        check("lin", {4'h0, kb.lin}, {4'h0, e.lin});
        check("col", {4'h0, kb.col}, {4'h0, e.col});
        check("lin_before_strobe", {4'h0, prev_lin}, {4'h0, e.lin});
        check("col_before_strobe", {4'h0, prev_col}, {4'h0, e.col});
`ifdef TECLADO_CODE_EN
        check("code", {4'h0, kb.code}, {4'h0, e.code});
        check("code_valid", {7'b0, kb.code_valid}, 8'h01);
`endif
      end
    end
    prev_lin   = kb.lin;
    prev_col   = kb.col;
    prev_press = kb.bot_press;
  end

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    key_row = r;
    key_col = c;
  endtask

  task automatic release_key();
    key_row = 4'b0000;
    key_col = 4'b0000;
  endtask

  task automatic wait_strobe(input int target, input string name);
    int n;
    n = 0;
    while (strobe_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (strobe_cnt < target) check({name, "_timeout"}, 8'h01, 8'h00);
  endtask

  task automatic wait_state(input state_t s, input string name);
    int n;
    n = 0;
    while (dut.state != s && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (dut.state != s) check({name, "_timeout"}, 8'h01, 8'h00);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_col_out"}, {4'h0, col_out}, 8'h08);
    check({name, "_lin"}, {4'h0, kb.lin}, 8'h00);
    check({name, "_col"}, {4'h0, kb.col}, 8'h00);
    check({name, "_bot_press"}, {7'b0, kb.bot_press}, 8'h00);
`ifdef TECLADO_CODE_EN
    check({name, "_code"}, {4'h0, kb.code}, 8'h00);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_seen;
    logic       frozen;
    int         base;
    int         n;

    checks     = 0;
    errors     = 0;
    strobe_cnt = 0;
    cyc        = 0;
    prev_lin   = '0;
    prev_col   = '0;
    prev_press = 1'b0;
    rst        = 1'b1;
    release_key();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Key 5 held steadily: one strobe only.
    exp_q.push_back('{lin: 4'h4, col: 4'h4, code: 4'h5});
    press(4'b0100, 4'b0100);
    wait_strobe(1, "key5");
    repeat (60) @(negedge clk);
    check("key5_strobe_count", 8'(strobe_cnt), 8'd1);
    release_key();
    repeat (30) @(negedge clk);

    // # then 0 with minimum strobe spacing.
    exp_q.push_back('{lin: 4'h1, col: 4'h2, code: 4'hF});
    press(4'b0001, 4'b0010);
    wait_strobe(2, "key_hash");
    release_key();
    repeat (12) @(negedge clk);
    exp_q.push_back('{lin: 4'h1, col: 4'h4, code: 4'h0});
    press(4'b0001, 4'b0100);
    wait_strobe(3, "key0");
    if (strobe_times.size() >= 3) begin
      check("hash_0_spacing_ge_18", {7'b0, (strobe_times[2] - strobe_times[1]) >= 18}, 8'h01);
    end else begin
      check("hash_0_spacing_missing", 8'h01, 8'h00);
    end
    release_key();
    repeat (30) @(negedge clk);

    // Key 9 bouncing 3 on / 3 off, then stable.
    key_col = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      key_row = (((i / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    check("bounce_no_strobe", 8'(strobe_cnt), 8'd3);
    exp_q.push_back('{lin: 4'h2, col: 4'h2, code: 4'h9});
    key_row = 4'b0010;
    wait_strobe(4, "key9");
    release_key();
    repeat (30) @(negedge clk);

    // Two rows on one column: ignored, scanning continues.
    press(4'b1100, 4'b0100);
    col_seen = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      col_seen = col_seen | col_out;
    end
    check("multirow_no_strobe", 8'(strobe_cnt), 8'd4);
    check("multirow_rotation", {4'h0, col_seen}, 8'h0F);
    release_key();
    repeat (10) @(negedge clk);

    // Reset during DEBOUNCE.
    press(4'b0010, 4'b1000);
    wait_state(DEBOUNCE, "rst_debounce");
    rst = 1'b1;
    release_key();
    @(negedge clk);
    check_reset_values("rst_debounce");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during STROBE: the strobe must never appear.
    press(4'b1000, 4'b1000);
    wait_state(STROBE, "rst_strobe");
    rst = 1'b1;
    release_key();
    @(negedge clk);
    check_reset_values("rst_strobe");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_strobe", 8'(strobe_cnt), 8'd4);

    // Key D held long: column frozen until the release is debounced.
    exp_q.push_back('{lin: 4'h1, col: 4'h1, code: 4'hD});
    press(4'b0001, 4'b0001);
    base = cyc;
    wait_strobe(5, "keyD");
    frozen = 1'b1;
    while ((cyc - base) < 200) begin
      @(negedge clk);
      if (col_out !== 4'b0001) frozen = 1'b0;
    end
    check("keyD_col_frozen_hold", {7'b0, frozen}, 8'h01);
    check("keyD_strobe_count", 8'(strobe_cnt), 8'd5);
    release_key();
    frozen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (col_out !== 4'b0001) frozen = 1'b0;
    end
    check("keyD_col_frozen_release", {7'b0, frozen}, 8'h01);
    n = 0;
    while (col_out !== 4'b1000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("keyD_rotation_resumes", {4'h0, col_out}, 8'h08);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
